// File: rtl/serial_negate_arbiter_pkg.sv
// Shared types and constants for the serial negation arbiter.
// Holds the controller state encoding, default sizes, and the most-negative word pattern.
package serial_negate_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_N_REQ = 2;

    // Pattern 1 followed by width-1 zeros; callers truncate to their width.
    function automatic logic [63:0] most_negative(input int width);
        return 64'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/serial_negate_arbiter_core.sv
// Bit-serial two's-complement negation core, LSB first.
// Output bit = a XOR seen-a-one; the seen flag is cleared synchronously by clr.
module serial_tc_core (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a,
    output logic s
);

    logic seen_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s        <= 1'b0;
            seen_reg <= 1'b0;
        end else if (clr) begin
            s        <= 1'b0;
            seen_reg <= 1'b0;
        end else if (en) begin
            s        <= a ^ seen_reg;
            seen_reg <= seen_reg | a;
        end
    end

endmodule

// File: rtl/serial_negate_arbiter.sv
// Round-robin arbiter sharing one serial negation core between N_REQ word producers.
// Each accepted word is streamed LSB-first through the core and reassembled for output.
module serial_negate_arbiter
    import serial_negate_arbiter_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int N_REQ = DEF_N_REQ,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic [W-1:0]       res_data,
    output logic [IDW-1:0]     res_id,
    output logic               res_ovf,
    input  logic               res_ready,
    output logic               busy
);

    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MOST_NEG = W'(most_negative(W));

    state_t         state_reg, state_next;
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] id_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   shift_reg;
    logic [W-1:0]   result_reg;
    logic           ovf_reg;

    logic [W-1:0]   req_word [N_REQ];
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           accept;
    logic           last_bit;
    logic           core_clr;
    logic           core_en;
    logic           core_out;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_word[gi]  = req_data[gi*W +: W];
            assign req_ready[gi] = (state_reg == IDLE) && grant_found && (grant_idx == IDW'(gi));
        end
    endgenerate

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(ptr_reg) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept   = (state_reg == IDLE) && grant_found;
    assign last_bit = (cnt_reg == CW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        res_valid  = 1'b0;
        busy       = 1'b1;
        core_clr   = 1'b0;
        core_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                busy     = 1'b0;
                core_clr = 1'b1;
                if (accept) state_next = SHIFT;
            end
            SHIFT: begin
                core_en = 1'b1;
                if (last_bit) state_next = FLUSH;
            end
            FLUSH: state_next = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Core output lags its input by one edge, so result capture starts at cnt=1 and ends in FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg    <= IDW'(N_REQ - 1);
            id_reg     <= '0;
            cnt_reg    <= '0;
            shift_reg  <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= req_word[grant_idx];
                        id_reg    <= grant_idx;
                        ptr_reg   <= grant_idx;
                        cnt_reg   <= '0;
                        ovf_reg   <= (req_word[grant_idx] == MOST_NEG);
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg != '0) result_reg <= {core_out, result_reg[W-1:1]};
                end
                FLUSH: result_reg <= {core_out, result_reg[W-1:1]};
                default: ;
            endcase
        end
    end

    serial_tc_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (core_clr),
        .en  (core_en),
        .a   (shift_reg[0]),
        .s   (core_out)
    );

    assign res_data = result_reg;
    assign res_id   = id_reg;
    assign res_ovf  = ovf_reg && res_valid;

endmodule

// File: tb/tb_serial_negate_arbiter.sv
// Self-checking bench for serial_negate_arbiter: vector table, corner sequences,
// randomized arbitration and a full input sweep against an arithmetic reference.
module tb_serial_negate_arbiter;

    localparam int W     = 8;
    localparam int N_REQ = 2;
    localparam int IDW   = $clog2(N_REQ);

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               res_valid;
    logic [W-1:0]       res_data;
    logic [IDW-1:0]     res_id;
    logic               res_ovf;
    logic               res_ready;
    logic               busy;

    int n_cmp = 0;
    int n_bad = 0;
    int rr_ptr;
    int multi_grant = 0;

    typedef struct {
        int           id;
        logic [W-1:0] x;
        logic [W-1:0] exp_data;
        logic         exp_ovf;
        int           hold;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    serial_negate_arbiter #(.W(W), .N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if ($countones(req_ready) > 1) multi_grant++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_neg(input logic [W-1:0] x);
        return W'(((2 ** W) - int'(x)) % (2 ** W));
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x);
        return int'(x) == (2 ** (W - 1));
    endfunction

    function automatic int model_grant(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rr_ptr = N_REQ - 1;
    endtask

    // Bounded wait for the grant to the expected requester while in IDLE.
    task automatic wait_grant(input int exp_id, output bit found);
        found = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (req_ready != '0) begin
                found = 1;
                break;
            end
            tick();
        end
        check("grant_seen", 64'(found), 64'(1));
        if (found) check("grant_onehot", 64'(req_ready), 64'(1) << exp_id);
    endtask

    // Called just after the accept edge; checks latency, result, backpressure, release.
    task automatic wait_result(input int exp_id, input logic [W-1:0] exp_data,
                               input logic exp_ovf, input int hold);
        int           lat;
        logic [W-1:0] d;
        logic [IDW-1:0] id;
        res_ready = (hold == 0);
        check("busy_after_accept", 64'(busy), 64'(1));
        lat = 0;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(W + 1));
        check("res_data", 64'(res_data), 64'(exp_data));
        check("res_id", 64'(res_id), 64'(exp_id));
        check("res_ovf", 64'(res_ovf), 64'(exp_ovf));
        $display("txn id=%0d data=%h ovf=%b latency=%0d hold=%0d", res_id, res_data, res_ovf, lat, hold);
        d  = res_data;
        id = res_id;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 64'(res_valid), 64'(1));
            check("hold_data", 64'(res_data), 64'(d));
            check("hold_id", 64'(res_id), 64'(id));
            check("hold_no_ready", 64'(req_ready), 64'(0));
        end
        res_ready = 1'b1;
        tick();
        check("release", 64'(res_valid), 64'(0));
        rr_ptr = exp_id;
    endtask

    task automatic send(input int id, input logic [W-1:0] x, input int hold,
                        input logic [W-1:0] exp_data, input logic exp_ovf);
        bit found;
        req_valid     = '0;
        req_valid[id] = 1'b1;
        req_data[id*W +: W] = x;
        wait_grant(id, found);
        if (!found) begin
            req_valid = '0;
            return;
        end
        tick();
        req_valid = '0;
        req_data  = ~req_data;
        wait_result(id, exp_data, exp_ovf, hold);
    endtask

    initial begin
        logic [W-1:0]     words [N_REQ];
        logic [N_REQ-1:0] mask;
        int               exp_id;
        int               seen;
        bit               found;

        vecs[0] = '{0, 8'h05, 8'hFB, 1'b0, 0};
        vecs[1] = '{1, 8'h00, 8'h00, 1'b0, 0};
        vecs[2] = '{0, 8'h80, 8'h80, 1'b1, 0};
        vecs[3] = '{1, 8'h01, 8'hFF, 1'b0, 5};
        vecs[4] = '{0, 8'h7F, 8'h81, 1'b0, 2};
        vecs[5] = '{1, 8'hFF, 8'h01, 1'b0, 0};
        vecs[6] = '{0, 8'h2A, 8'hD6, 1'b0, 0};
        vecs[7] = '{1, 8'h40, 8'hC0, 1'b0, 1};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        #1;
        check("reset_outputs", 64'({req_ready, res_valid, res_data, res_id, res_ovf, busy}), 64'(0));
        do_reset();

        for (int i = 0; i < 8; i++)
            send(vecs[i].id, vecs[i].x, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_ovf);

        // Valid dropped before any edge sees it: nothing is accepted.
        req_valid = 2'b01;
        #3;
        req_valid = '0;
        tick();
        check("drop_no_accept", 64'(busy), 64'(0));

        // Round robin with both requesters held valid from reset.
        do_reset();
        res_ready = 1'b1;
        words[0] = 8'h01;
        words[1] = 8'h7F;
        req_data  = {words[1], words[0]};
        req_valid = 2'b11;
        for (int r = 0; r < 4; r++) begin
            exp_id = model_grant(req_valid, rr_ptr);
            wait_grant(exp_id, found);
            if (!found) break;
            tick();
            wait_result(exp_id, model_neg(words[exp_id]), model_ovf(words[exp_id]), 0);
        end
        req_valid = '0;
        tick();

        // Reset in the middle of SHIFT discards the word.
        req_valid = 2'b10;
        req_data[W +: W] = 8'h33;
        wait_grant(1, found);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midshift_reset", 64'({req_ready, res_valid, res_data, res_id, res_ovf, busy}), 64'(0));
        tick();
        rst    = 1'b0;
        rr_ptr = N_REQ - 1;
        seen   = 0;
        for (int k = 0; k < W + 3; k++) begin
            tick();
            if (res_valid) seen++;
        end
        check("no_result_after_reset", 64'(seen), 64'(0));
        req_data  = {8'h55, 8'h2A};
        req_valid = 2'b11;
        wait_grant(0, found);
        tick();
        req_valid = '0;
        wait_result(0, 8'hD6, 1'b0, 0);

        // Randomized masks, data and backpressure.
        for (int r = 0; r < 60; r++) begin
            mask = N_REQ'($urandom_range(1, (2 ** N_REQ) - 1));
            for (int j = 0; j < N_REQ; j++) begin
                words[j] = W'($urandom);
                req_data[j*W +: W] = words[j];
            end
            req_valid = mask;
            exp_id = model_grant(mask, rr_ptr);
            wait_grant(exp_id, found);
            if (!found) break;
            tick();
            req_valid = '0;
            req_data  = N_REQ*W'($urandom);
            wait_result(exp_id, model_neg(words[exp_id]), model_ovf(words[exp_id]),
                        $urandom_range(0, 3));
        end

        // Exhaustive sweep of input words through alternating requesters.
        for (int x = 0; x < 2 ** W; x++)
            send(x % N_REQ, W'(x), 0, model_neg(W'(x)), model_ovf(W'(x)));

        check("ready_onehot", 64'(multi_grant), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
